// File: rtl/demux1x3_hs.sv
// One-to-three handshaked demultiplexer with a one-entry holding register per destination.
// Optional delivery counters are built when DEMUX1X3_HS_CNT_EN is defined.
module demux1x3_hs #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic [DATA_W-1:0] out2_data,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic              err_sel
`ifdef DEMUX1X3_HS_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
  output logic [15:0]       cnt2
`endif
);

  // Handshake: a word moves on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and a holder may refill in the cycle it drains.
  logic [DATA_W-1:0] data_q [3];
  logic [2:0]        valid_q;
  logic [2:0]        load;
  logic [3:0]        blocked;
  logic              accept;
  logic              err_q;

  // Select 3 maps onto the always-free top bit, so illegal words are always taken.
  assign blocked  = {1'b0, valid_q & ~out_ready};
  assign in_ready = ~blocked[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < 3; i++) begin : g_dest
    assign load[i] = accept & (in_sel == 2'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end else if (load[i]) begin
        valid_q[i] <= 1'b1;
        data_q[i]  <= in_data;
      end else if (out_ready[i]) begin
        valid_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & (in_sel == 2'd3);
    end
  end

  assign out0_data = data_q[0];
  assign out1_data = data_q[1];
  assign out2_data = data_q[2];
  assign out_valid = valid_q;
  assign err_sel   = err_q;

`ifdef DEMUX1X3_HS_CNT_EN
  logic [15:0] cnt_q [3];

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (valid_q[i] && out_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_demux1x3_hs.sv
// Bench for demux1x3_hs: directed scenarios with literal expectations plus a random
// stream checked every cycle against a queue-based model of the three holders.
module tb_demux1x3_hs;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data;
  logic [DATA_W-1:0] out1_data;
  logic [DATA_W-1:0] out2_data;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic              err_sel;
`ifdef DEMUX1X3_HS_CNT_EN
  logic              cnt_clr;
  logic [15:0]       cnt0;
  logic [15:0]       cnt1;
  logic [15:0]       cnt2;
`endif

  int errors = 0;
  int checks = 0;

  demux1x3_hs #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel)
`ifdef DEMUX1X3_HS_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each destination is a queue holding at most one word; the head is what the port shows.
  logic [DATA_W-1:0] exp_q [3][$];
  logic              err_exp;

  function automatic bit model_ready(logic [1:0] sel, logic [2:0] ordy);
    if (sel == 2'd3) return 1'b1;
    return (exp_q[sel].size() == 0) || ordy[sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      err_exp = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && model_ready(in_sel, out_ready);
      err_exp = acc && (in_sel == 2'd3);
      for (int i = 0; i < 3; i++) begin
        if (out_ready[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        if (acc && in_sel == 2'(i)) exp_q[i].push_back(in_data);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] port_data(int i);
    case (i)
      0:       return out0_data;
      1:       return out1_data;
      default: return out2_data;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", 64'(in_ready), 64'(model_ready(in_sel, out_ready)));
      check("model_err_sel", 64'(err_sel), 64'(err_exp));
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_valid%0d", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0)
          check($sformatf("model_data%0d", i), 64'(port_data(i)), 64'(exp_q[i][0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] sel, logic [DATA_W-1:0] d, logic [2:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic drain_all();
    drive(1'b0, 2'd0, '0, 3'b111);
    step();
    step();
    drive(1'b0, 2'd0, '0, 3'b000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, '0, 3'b000);
`ifdef DEMUX1X3_HS_CNT_EN
    cnt_clr = 1'b0;
`endif
    step();
    step();
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_err", 64'(err_sel), 64'd0);
    check("reset_data0", 64'(out0_data), 64'd0);
    rst_n = 1'b1;

    // single word to out1 with everything stalled, then a blocked second word
    step();
    drive(1'b1, 2'd1, 32'hDEADBEEF, 3'b000);
    @(negedge clk);
    check("s1_ready_first", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 2'd1, 32'h12345678, 3'b000);
    @(negedge clk);
    check("s1_out_valid", 64'(out_valid), 64'b010);
    check("s1_out1_data", 64'(out1_data), 64'hDEADBEEF);
    check("s1_ready_blocked", 64'(in_ready), 64'd0);
    step();
    drain_all();

    // back-to-back words through a free-running out0
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd0, DATA_W'(k), 3'b001);
      @(negedge clk);
      check($sformatf("s2_ready%0d", k), 64'(in_ready), 64'd1);
      if (k > 1) check($sformatf("s2_data%0d", k - 1), 64'(out0_data), 64'(k - 1));
      step();
    end
    drive(1'b0, 2'd0, '0, 3'b001);
    @(negedge clk);
    check("s2_data4", 64'(out0_data), 64'd4);
    step();
    drain_all();

    // out2 full and stalled must not block out0
    drive(1'b1, 2'd2, 32'h22222222, 3'b000);
    step();
    drive(1'b1, 2'd2, 32'h33333333, 3'b000);
    @(negedge clk);
    check("s3_out2_blocked", 64'(in_ready), 64'd0);
    step();
    drive(1'b1, 2'd0, 32'hA5A5A5A5, 3'b000);
    @(negedge clk);
    check("s3_out0_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 2'd0, '0, 3'b000);
    @(negedge clk);
    check("s3_out0_data", 64'(out0_data), 64'hA5A5A5A5);
    check("s3_out2_data", 64'(out2_data), 64'h22222222);
    check("s3_out_valid", 64'(out_valid), 64'b101);

    // illegal select is swallowed with a one-cycle error pulse
    step();
    drive(1'b1, 2'd3, 32'hBADBAD00, 3'b000);
    @(negedge clk);
    check("s4_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 2'd0, '0, 3'b000);
    @(negedge clk);
    check("s4_err_pulse", 64'(err_sel), 64'd1);
    check("s4_valid_kept", 64'(out_valid), 64'b101);
    step();
    @(negedge clk);
    check("s4_err_clear", 64'(err_sel), 64'd0);
    step();
    drain_all();

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), DATA_W'($urandom),
            3'($urandom_range(0, 7)));
      step();
    end
    drain_all();

    // asynchronous reset with all holders full, mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 32'h0F0F0000 + DATA_W'(i), 3'b000);
      step();
    end
    drive(1'b0, 2'd0, '0, 3'b000);
    @(negedge clk);
    check("s5_all_full", 64'(out_valid), 64'b111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_valid_cleared", 64'(out_valid), 64'd0);
    check("s5_data_cleared", 64'({out0_data, out1_data} | 64'(out2_data)), 64'd0);
    drive(1'b1, 2'd0, 32'h77777777, 3'b001);
    step();
    check("s5_no_accept_in_reset", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drain_all();

`ifdef DEMUX1X3_HS_CNT_EN
    // counter saturation and clear-over-increment
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int n = 0; n < 70010; n++) begin
      drive(1'b1, 2'd1, DATA_W'(n), 3'b010);
      step();
    end
    @(negedge clk);
    check("cnt1_saturated", 64'(cnt1), 64'hFFFF);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt1_cleared", 64'(cnt1), 64'd0);
    drain_all();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1x3_hs.md
DEMUX1X3_HS -- requirements
Module: demux1x3_hs

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data path width.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data  input  DATA_W  the word to route.
REQ-005 The block SHALL have port in_sel  input  2  destination select: 0 = out0, 1 = out1, 2 = out2, 3 = illegal.
REQ-006 The block SHALL have port in_valid  input  1  in_data/in_sel are valid this cycle.
REQ-007 The block SHALL have port in_ready  output  1  the block accepts the word this cycle.
REQ-008 The block SHALL have ports out0_data, out1_data, out2_data  output  DATA_W each  per-destination held words.
REQ-009 The block SHALL have port out_valid  output  3  bit i = out<i>_data holds a word.
REQ-010 The block SHALL have port out_ready  input  3  bit i = destination i consumes its word this cycle.
REQ-011 The block SHALL have port err_sel  output  1  one-cycle pulse after an illegal select is accepted.

Function
REQ-012 Each destination i SHALL own a one-entry holding register (data_q[i], valid_q[i]); out<i>_data = data_q[i] and out_valid[i] = valid_q[i].
REQ-013 in_ready SHALL be the combinational value (in_sel==3) | ~valid_q[in_sel] | out_ready[in_sel].
REQ-014 A transfer SHALL be accepted in any cycle where in_valid & in_ready.
REQ-015 On acceptance with in_sel=i<3, the next cycle SHALL show data_q[i]=in_data and valid_q[i]=1, a latency of exactly 1 cycle.
REQ-016 When valid_q[i] & out_ready[i] and there is no acceptance to i in the same cycle, valid_q[i] SHALL clear on the next edge.
REQ-017 When a drain and an acceptance hit the same destination in the same cycle, valid_q[i] SHALL stay 1 and data_q[i] SHALL load the new word, giving one word per cycle per destination.
REQ-018 While valid_q[i] & ~out_ready[i], data_q[i] SHALL remain stable.
REQ-019 Destinations SHALL be independent; a stalled destination SHALL NOT block transfers to other destinations.
REQ-020 An accepted transfer with in_sel=3 SHALL be discarded, SHALL leave all holding registers unchanged, and SHALL assert err_sel for exactly the next cycle.
REQ-021 When in_valid=0, in_ready MAY be 1, and no state SHALL change except draining.

Reset
REQ-022 Assertion of rst_n=0 SHALL immediately clear valid_q to 3'b000, data_q to 0 and err_sel to 0, independent of clk.
REQ-023 Held words present at reset SHALL be lost.
REQ-024 No transfer SHALL be accepted during the first edge at which rst_n is sampled 0.

Configuration
REQ-025 With macro DEMUX1X3_HS_CNT_EN defined, the block SHALL add input cnt_clr (1 bit) and outputs cnt0, cnt1, cnt2 (16 bits each), with cnt<i> counting deliveries (valid_q[i] & out_ready[i]).
REQ-026 The counters SHALL saturate at 16'hFFFF.
REQ-027 cnt_clr SHALL zero all counters synchronously, with priority over any increment.
REQ-028 Reset SHALL zero all counters.
REQ-029 Without DEMUX1X3_HS_CNT_EN, these ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: in_sel=1, in_data=32'hDEADBEEF, in_valid=1, out_ready=3'b000 -> next cycle out_valid=3'b010 and out1_data=DEADBEEF; a second word to sel=1 sees in_ready=0.
REQ-031 Scenario: out_ready[0]=1 held and 4 back-to-back words 1,2,3,4 sent to sel=0 -> in_ready=1 throughout and out0_data shows 1,2,3,4 on consecutive cycles.
REQ-032 Scenario: out2 stalled and full, then a word A5A5A5A5 is sent to sel=0 -> it is accepted, and out2_data stays unchanged.
REQ-033 Scenario: in_sel=3, in_valid=1 -> in_ready=1, err_sel=1 for one cycle, and out_valid is unchanged.
REQ-034 Scenario: rst_n driven low mid-cycle with out_valid=3'b111 -> out_valid=0 and data=0 before the next clk edge.
REQ-035 Scenario (CNT_EN): 70000 deliveries on out1 -> cnt1=FFFF; then cnt_clr=1 -> cnt1=0 next cycle, even when a delivery occurs in that same cycle.
